// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - byte stream in and Avalon-MM master bundle of uart_tx_feeder
interface uart_tx_feeder_if;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [3:0] avmm_address_o;
  logic       avmm_read_o;
  logic       avmm_write_o;
  logic [7:0] avmm_writedata_o;
  logic [7:0] avmm_readdata_i;

  modport master (
    input  s_data_i, s_valid_i, avmm_readdata_i,
    output s_ready_o, avmm_address_o, avmm_read_o, avmm_write_o, avmm_writedata_o
  );

  modport slave (
    output s_data_i, s_valid_i, avmm_readdata_i,
    input  s_ready_o, avmm_address_o, avmm_read_o, avmm_write_o, avmm_writedata_o
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO drained into uart_core by status polling and data writes
// Macro UART_TX_FEEDER_TIMEOUT_EN adds poll timeout, head-byte drop and sticky err_o.
module uart_tx_feeder #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [3:0]  STATUS_ADDR  = 4'h1,
  parameter logic [3:0]  DATA_ADDR    = 4'h0,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  uart_tx_feeder_if.master            bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        idle_o
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  ,
  output logic                        err_o
`endif
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] RL_LAST  = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(POLL_GAP - 1);
  localparam logic [LW-1:0] DEPTH    = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_POLL, ST_WAIT, ST_GAP, ST_WRITE, ST_SETTLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          s_ready_q, s_ready_d, read_q, read_d, write_q, write_d, idle_q, idle_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          push, pop;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [TW-1:0] POLL_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] polls_q, polls_d;
  logic          err_q, err_d;
  logic          unused_bits;
  assign unused_bits = ^bus.avmm_readdata_i[7:1];
  assign err_o = err_q;
`else
  logic unused_bits;
  assign unused_bits = ^{bus.avmm_readdata_i[7:1], 32'(TIMEOUT)};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    push     = bus.s_valid_i & s_ready_q;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    polls_d  = polls_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE:   if (level_q != '0) state_d = ST_POLL;
      ST_POLL: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      // readdata is valid READ_LATENCY cycles after the strobe, i.e. in the last WAIT cycle
      ST_WAIT: begin
        if (cnt_q == RL_LAST) begin
          cnt_d = '0;
          if (bus.avmm_readdata_i[0]) begin
            state_d = ST_WRITE;
          end else begin
`ifdef UART_TX_FEEDER_TIMEOUT_EN
            if (polls_q == POLL_LAST) begin
              state_d = ST_IDLE;
              pop     = 1'b1;
              err_d   = 1'b1;
              polls_d = '0;
            end else begin
              state_d = ST_GAP;
              polls_d = polls_q + 1'b1;
            end
`else
            state_d = ST_GAP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_POLL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        pop     = 1'b1;
        state_d = ST_SETTLE;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        polls_d = '0;
`endif
      end
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d   = level_q + LW'(push) - LW'(pop);
    s_ready_d = level_d < DEPTH;
    idle_d    = (state_d == ST_IDLE) && (level_d == '0);
    // Strobes are registered from the next state so they line up with state_q
    read_d    = (state_d == ST_POLL);
    write_d   = (state_d == ST_WRITE);
    addr_d    = write_d ? DATA_ADDR : STATUS_ADDR;
    wdata_d   = write_d ? mem_q[rd_ptr_q] : wdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b0;
      idle_q    <= 1'b1;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= STATUS_ADDR;
      wdata_q   <= '0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
      polls_q   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      s_ready_q <= s_ready_d;
      idle_q    <= idle_d;
      read_q    <= read_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
      polls_q   <= polls_d;
      err_q     <= err_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.s_data_i;
  end

  assign bus.s_ready_o        = s_ready_q;
  assign bus.avmm_address_o   = addr_q;
  assign bus.avmm_read_o      = read_q;
  assign bus.avmm_write_o     = write_q;
  assign bus.avmm_writedata_o = wdata_q;
  assign fifo_level_o         = level_q;
  assign idle_o               = idle_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed vector bench for uart_tx_feeder with a uart_core status/data model
module tb_uart_tx_feeder;
  localparam int RL      = 1;
  localparam int GAP     = 4;
  localparam int SPACING = GAP + 1 + RL;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [4:0] level;
  logic       idle;
  logic [7:0] rdata = 8'h00;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  logic       err;
`endif

  uart_tx_feeder_if bus();

  uart_tx_feeder #(
    .FIFO_DEPTH(16), .STATUS_ADDR(4'h1), .DATA_ADDR(4'h0),
    .READ_LATENCY(RL), .POLL_GAP(GAP), .TIMEOUT(8)
  ) dut (
    .clk_i(clk),
    .srst_i(srst),
    .bus(bus.master),
    .fifo_level_o(level),
    .idle_o(idle)
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    ,
    .err_o(err)
`endif
  );

  always #5 clk = ~clk;

  assign bus.avmm_readdata_i = rdata;

  int total = 0;
  int bad   = 0;

  // uart_core model: status ready once ready_after reads have been answered and not stalled
  int         cyc = 0;
  int         reads = 0;
  int         ready_after = 0;
  logic       stall = 1'b0;
  int         read_cyc[$];
  logic [7:0] wr_q[$];
  int         rw_both = 0;
  int         addr_bad = 0;
  int         max_level = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!srst) begin
      if (bus.avmm_read_o && bus.avmm_write_o) rw_both++;
      if ($isunknown(bus.avmm_address_o)) addr_bad++;
      else if (bus.avmm_write_o && bus.avmm_address_o != 4'h0) addr_bad++;
      else if (!bus.avmm_write_o && bus.avmm_address_o != 4'h1) addr_bad++;
      if (int'(level) > max_level) max_level = int'(level);
      if (bus.avmm_read_o) begin
        rdata = {7'b1010101, (!stall && reads >= ready_after)};
        read_cyc.push_back(cyc);
        reads++;
      end
      if (bus.avmm_write_o) wr_q.push_back(bus.avmm_writedata_o);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge following acceptance
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = b;
    while (!bus.s_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.s_valid_i = 1'b0;
    if (n >= 2000) chk("push_accept_budget", n, 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!idle && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_reached"}, int'(n < 1000), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         busy;
    int         exp_polls;
    logic [7:0] exp_wdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int r0, w0, n;
    vecs[0] = '{data: 8'h13, busy: 0, exp_polls: 1, exp_wdata: 8'h13};
    vecs[1] = '{data: 8'hA5, busy: 2, exp_polls: 3, exp_wdata: 8'hA5};
    vecs[2] = '{data: 8'h00, busy: 1, exp_polls: 2, exp_wdata: 8'h00};
    vecs[3] = '{data: 8'hFF, busy: 0, exp_polls: 1, exp_wdata: 8'hFF};

    bus.s_valid_i = 1'b0;
    bus.s_data_i  = 8'h00;

    // Reset held three cycles
    repeat (3) @(negedge clk);
    chk("rst_s_ready", int'(bus.s_ready_o), 0);
    chk("rst_read", int'(bus.avmm_read_o), 0);
    chk("rst_write", int'(bus.avmm_write_o), 0);
    chk("rst_addr", int'(bus.avmm_address_o), 1);
    chk("rst_wdata", int'(bus.avmm_writedata_o), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_idle", int'(idle), 1);
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    chk("rst_err", int'(err), 0);
`endif
    srst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_release", int'(bus.s_ready_o), 1);

    // Single bytes with varying not-ready polls
    for (int i = 0; i < 4; i++) begin
      r0 = reads;
      w0 = wr_q.size();
      ready_after = reads + vecs[i].busy;
      push_byte(vecs[i].data);
      chk($sformatf("vec%0d_busy_after_push", i), int'(idle), 0);
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_polls", i), reads - r0, vecs[i].exp_polls);
      chk($sformatf("vec%0d_nwrites", i), wr_q.size() - w0, 1);
      if (wr_q.size() > w0) chk($sformatf("vec%0d_wdata", i), int'(wr_q[w0]), int'(vecs[i].exp_wdata));
      for (int k = 1; k < vecs[i].exp_polls && r0 + k < read_cyc.size(); k++)
        chk($sformatf("vec%0d_spacing%0d", i, k), read_cyc[r0+k] - read_cyc[r0+k-1], SPACING);
      chk($sformatf("vec%0d_level", i), int'(level), 0);
    end

    // Backpressure: three bytes, first answered not-ready three times
    r0 = reads;
    w0 = wr_q.size();
    ready_after = reads + 3;
    push_byte(8'h37);
    push_byte(8'h17);
    push_byte(8'h19);
    wait_idle("bp");
    chk("bp_nwrites", wr_q.size() - w0, 3);
    chk("bp_polls", reads - r0, 6);
    if (wr_q.size() >= w0 + 3) begin
      chk("bp_w0", int'(wr_q[w0]), 8'h37);
      chk("bp_w1", int'(wr_q[w0+1]), 8'h17);
      chk("bp_w2", int'(wr_q[w0+2]), 8'h19);
    end
    for (int k = 1; k < 4 && r0 + k < read_cyc.size(); k++)
      chk($sformatf("bp_spacing%0d", k), read_cyc[r0+k] - read_cyc[r0+k-1], SPACING);

    // Full FIFO under a stalled status
    w0 = wr_q.size();
    stall = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    chk("full_level", int'(level), 16);
    chk("full_s_ready", int'(bus.s_ready_o), 0);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 8'h50;
    repeat (10) @(negedge clk);
    chk("full_hold_level", int'(level), 16);
    chk("full_no_writes", wr_q.size() - w0, 0);
    ready_after = reads;
    stall = 1'b0;
    push_byte(8'h50);
    chk("full_accept_after_first_pop", wr_q.size() - w0, 1);
    wait_idle("full");
    chk("full_nwrites", wr_q.size() - w0, 17);
    if (wr_q.size() >= w0 + 17)
      for (int i = 0; i < 17; i++)
        chk($sformatf("full_order%0d", i), int'(wr_q[w0+i]), (i < 16) ? 8'h40 + i : 8'h50);
    chk("full_max_level", max_level, 16);

    // Reset asserted during the WRITE cycle
    ready_after = reads;
    push_byte(8'h99);
    n = 0;
    while (!bus.avmm_write_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_write_seen", int'(bus.avmm_write_o), 1);
    chk("mid_write_data", int'(bus.avmm_writedata_o), 8'h99);
    w0 = wr_q.size();
    srst = 1'b1;
    @(negedge clk);
    chk("mid_rst_write", int'(bus.avmm_write_o), 0);
    chk("mid_rst_read", int'(bus.avmm_read_o), 0);
    chk("mid_rst_level", int'(level), 0);
    srst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_more_writes", wr_q.size() - w0, 0);
    chk("mid_rst_idle", int'(idle), 1);

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    // Timeout drops the head byte and latches err_o
    r0 = reads;
    w0 = wr_q.size();
    stall = 1'b1;
    push_byte(8'h41);
    n = 0;
    while (!err && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("to_err", int'(err), 1);
    chk("to_polls", reads - r0, 8);
    chk("to_no_write", wr_q.size() - w0, 0);
    chk("to_level", int'(level), 0);
    stall = 1'b0;
    ready_after = reads;
    push_byte(8'h55);
    wait_idle("to_next");
    chk("to_next_nwrites", wr_q.size() - w0, 1);
    if (wr_q.size() > w0) chk("to_next_data", int'(wr_q[w0]), 8'h55);
    chk("to_err_sticky", int'(err), 1);
`endif

    chk("rw_exclusive", rw_both, 0);
    chk("addr_legal", addr_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
